buffer_rr_arbiter: RTL and testbench
====================================

Name: buffer_rr_arbiter

Overview:
- Shares one registered buffer stage between NREQ requesters using round-robin arbitration.
- Each requester presents a request and a data word. The winner's word is captured into the buffer and presented downstream with a valid/ready handshake.
- Sits in front of the buffer datapath. It is the only block that writes the shared buffer.
- Also keeps a wrap-around count of accepted transfers, for debug and bench checking.

Parameters:
- NREQ, 4: number of requesters. Minimum 2, power of two.
- DW, 8: data width per requester.
- CW, 16: width of the transfer counter.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request. Bit i belongs to requester i.
- req_data  in  NREQ*DW  concatenated data. Requester i uses bits [i*DW +: DW].
- gnt  out  NREQ  one-hot accept strobe, combinational, same cycle as the capture edge.
- out_valid  out  1  buffer holds a word.
- out_data  out  DW  buffered word.
- out_src  out  log2(NREQ)  index of the requester that supplied out_data.
- out_ready  in  1  downstream accepts the word this cycle.
- xfer_cnt  out  CW  number of words accepted into the buffer, modulo 2^CW.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_src=0, xfer_cnt=0.
  - Round-robin pointer ptr=0.
  - gnt=0 while rst is high.
- Buffer free condition: free = !out_valid || out_ready. The buffer accepts a new word in the same cycle it drains (full throughput, no bubble).
- Arbitration (combinational):
  - Scan requesters ptr, ptr+1, …, ptr+NREQ-1 (mod NREQ).
  - The winner is the first requester with req=1.
  - accept = free && |req && !rst.
- gnt:
  - gnt = onehot(winner) when accept, else 0.
  - At most one bit is set.
  - Never asserted while the buffer is full and out_ready=0.
- On a clk edge with accept:
  - out_data <= req_data[winner], out_src <= winner, out_valid <= 1.
  - ptr <= (winner+1) mod NREQ.
  - xfer_cnt <= xfer_cnt+1. Wraps from 2^CW-1 to 0.
- On a clk edge without accept and with out_ready=1: out_valid <= 0. out_data and out_src keep their values.
- On a clk edge without accept and with out_ready=0: all state holds.
- Stability: while out_valid=1 and out_ready=0, out_data and out_src do not change.
- Requester rules:
  - Hold req and req_data stable until gnt[i] is seen.
  - Dropping req before the grant is legal. It simply withdraws the request.
  - req_data is ignored for non-granted requesters.
- Fairness: a requester that holds req is granted within NREQ accepted transfers.
- ptr changes only on accept. Idle cycles and stall cycles do not rotate priority.
- out_ready while out_valid=0: has no effect except that free=1.
- Reset mid-transfer: the buffered word is discarded (out_valid=0) and ptr returns to 0. Any gnt pulse in that cycle is suppressed.
- Latency: a requester's data appears on out_data 1 cycle after the gnt edge.
- Throughput: with out_ready held high, 1 word per cycle.

Test Plan (NREQ=4, DW=8, CW=16 unless stated):
- Reset check: assert rst for 2 cycles, then release.
  - During reset: out_valid=0, out_data=0x00, xfer_cnt=0, gnt=0.
- Single requester: req=0001, req_data[7:0]=0xA5, out_ready=1.
  - gnt=0001.
  - Next cycle: out_valid=1, out_data=0xA5, out_src=0, xfer_cnt=1.
- Round-robin rotation: all four requesters request continuously with data 0x10, 0x11, 0x12, 0x13; out_ready=1.
  - Grant order 0,1,2,3,0,…
  - out_data sequence 0x10, 0x11, 0x12, 0x13, 0x10.
  - One word per cycle.
- Backpressure: buffer holds 0x11 (out_src=1) and out_ready=0 for 3 cycles while req=1111.
  - gnt=0 throughout. out_data stays 0x11. xfer_cnt does not change.
  - out_ready=1 then grants requester 2 in the same cycle. Next out_data=0x12.
- Drain without refill: out_valid=1, req=0000, out_ready=1.
  - Next cycle out_valid=0. ptr is unchanged.
  - A later req=1111 is granted to the requester after the previous winner.
- Mid-transfer reset: out_valid=1 holding 0x13 with out_ready=0; assert rst for 1 cycle.
  - out_valid=0, xfer_cnt=0.
  - Next req=1111 grants requester 0.
- Counter wrap: run with CW=4 for 17 accepted transfers.
  - xfer_cnt reaches 15, then 0, then 1.

Source files
------------

// File: rtl/buffer_rr_arbiter.sv
// Round-robin arbiter feeding one shared registered buffer stage with a valid/ready output.
// Also counts accepted transfers modulo 2^CW.
module buffer_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned CW   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(NREQ)-1:0]  out_src,
    input  logic                     out_ready,
    output logic [CW-1:0]            xfer_cnt
);

    localparam int unsigned SW = $clog2(NREQ);

    logic [SW-1:0] ptr;
    logic [SW-1:0] winner;
    logic [SW-1:0] idx;
    logic          found;
    logic          free;
    logic          accept;

    // Scan from ptr upward with natural power-of-two wrap; first requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = ptr + SW'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        free   = !out_valid || out_ready;
        accept = free && found && !rst;
        gnt    = '0;
        if (accept) begin
            gnt[winner] = 1'b1;
        end
    end

    // Buffer, priority pointer and transfer counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            xfer_cnt  <= '0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= req_data[32'(winner)*DW +: DW];
            out_src   <= winner;
            xfer_cnt  <= xfer_cnt + CW'(1);
            ptr       <= winner + SW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_buffer_rr_arbiter.sv
// Bench for buffer_rr_arbiter: directed plan steps then constrained-random traffic,
// checked against a transaction-level model; a CW=4 twin checks counter wrap.
module tb_buffer_rr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ*DW-1:0] req_data;
    logic            out_ready;

    logic [NREQ-1:0] gnt, gnt4;
    logic            out_valid, out_valid4;
    logic [DW-1:0]   out_data, out_data4;
    logic [1:0]      out_src, out_src4;
    logic [15:0]     xfer_cnt;
    logic [3:0]      xfer_cnt4;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_valid, m_data, m_src, m_ptr, m_cnt;
    int waitc [NREQ];
    logic [NREQ-1:0] last_gnt;

    buffer_rr_arbiter #(.NREQ(NREQ), .DW(DW), .CW(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    buffer_rr_arbiter #(.NREQ(NREQ), .DW(DW), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt4),
        .out_valid(out_valid4), .out_data(out_data4), .out_src(out_src4),
        .out_ready(out_ready), .xfer_cnt(xfer_cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational grant before the edge, registered state after it.
    task automatic tick();
        int win;
        int acc;
        int j;
        logic [NREQ-1:0] exp_gnt;
        #1;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (req[j] && win < 0) win = j;
        end
        acc = (m_valid == 0 || out_ready) && win >= 0 && !rst;
        exp_gnt = acc ? NREQ'(1) << win : '0;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("gnt_cw4", 32'(gnt4), 32'(exp_gnt));
        // Fairness: a holding requester sees its grant within NREQ accepts.
        if (|gnt && !rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    chk("fair", 32'(waitc[i] < NREQ), 32'd1);
                    waitc[i] = 0;
                end else if (req[i]) begin
                    waitc[i]++;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) if (!req[i] || rst) waitc[i] = 0;
        last_gnt = gnt;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0; m_cnt = 0;
        end else if (acc) begin
            m_valid = 1;
            m_data  = int'(req_data[win*DW +: DW]);
            m_src   = win;
            m_ptr   = (win + 1) % NREQ;
            m_cnt   = (m_cnt + 1) % 65536;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_src", 32'(out_src), 32'(m_src));
        chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
        chk("xfer_cnt_cw4", 32'(xfer_cnt4), 32'(m_cnt % 16));
    endtask

    task automatic set_rot_data();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 8'(8'h10 + i);
    endtask

    initial begin
        m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0; m_cnt = 0;
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        last_gnt = '0;
        rst = 1'b1; req = '0; req_data = '0; out_ready = 1'b0;

        // Reset for two cycles.
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_cnt", 32'(xfer_cnt), 32'd0);
        rst = 1'b0;

        // Single requester.
        req = 4'b0001; req_data[7:0] = 8'hA5; out_ready = 1'b1;
        #1; chk("single_gnt", 32'(gnt), 32'b0001);
        tick();
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_cnt", 32'(xfer_cnt), 32'd1);

        // Rotation from ptr=0.
        rst = 1'b1; req = '0; tick(); rst = 1'b0;
        req = 4'b1111; set_rot_data();
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("rot_data", 32'(out_data), 32'(8'h10 + (n % 4)));
        end

        // Backpressure with 0x11 held.
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();
        chk("bp_hold_data", 32'(out_data), 32'h11);
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("bp_stall_data", 32'(out_data), 32'h11);
            chk("bp_stall_cnt", 32'(xfer_cnt), 32'd2);
        end
        out_ready = 1'b1;
        #1; chk("bp_release_gnt", 32'(gnt), 32'b0100);
        tick();
        chk("bp_release_data", 32'(out_data), 32'h12);

        // Drain without refill, then next requester after previous winner.
        req = '0; tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        tick();
        req = 4'b1111;
        #1; chk("drain_next_gnt", 32'(gnt), 32'b1000);
        tick();
        chk("drain_next_data", 32'(out_data), 32'h13);

        // Mid-transfer reset.
        out_ready = 1'b0; req = '0; tick();
        rst = 1'b1; req = 4'b1111; tick(); rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
        out_ready = 1'b1;
        #1; chk("mid_rst_gnt", 32'(gnt), 32'b0001);
        tick();

        // Counter wrap on the CW=4 instance.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            tick();
            if (n == 15) chk("wrap_15", 32'(xfer_cnt4), 32'd15);
            if (n == 16) chk("wrap_0", 32'(xfer_cnt4), 32'd0);
            if (n == 17) chk("wrap_1", 32'(xfer_cnt4), 32'd1);
        end

        // Random traffic honouring the hold-until-grant rule (drops allowed).
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || last_gnt[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    req_data[i*DW +: DW] = 8'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
